// File: rtl/mat_mul_sequencer.sv
// Time-multiplexed matrix multiplier: one shared EW x EW MAC walks (i, j, k)
// one product per cycle and assembles the row-major packed result matrix.
module mat_mul_sequencer #(
    parameter int unsigned A_ROW = 4,
    parameter int unsigned A_COL = 4,
    parameter int unsigned B_COL = 2,
    parameter int unsigned EW    = 8,
    parameter int unsigned RW    = 8,
    localparam int unsigned A_LEN = A_ROW * A_COL * EW,
    localparam int unsigned B_LEN = A_COL * B_COL * EW,
    localparam int unsigned R_LEN = A_ROW * B_COL * RW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [A_LEN-1:0] a_in,
    input  logic [B_LEN-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [R_LEN-1:0] res
);

    localparam int unsigned IW   = (A_ROW > 1) ? $clog2(A_ROW) : 1;
    localparam int unsigned JW   = (B_COL > 1) ? $clog2(B_COL) : 1;
    localparam int unsigned KW   = (A_COL > 1) ? $clog2(A_COL) : 1;
    localparam int unsigned PW   = 2 * EW;
    localparam int unsigned ACCW = PW + $clog2(A_COL);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [A_LEN-1:0]  a_q, a_d;
    logic [B_LEN-1:0]  b_q, b_d;
    logic [IW-1:0]     i_q, i_d;
    logic [JW-1:0]     j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [R_LEN-1:0]  res_d;
    logic              busy_d, done_d;

    logic              i_last, j_last, k_last;
    int unsigned       a_shift, b_shift, r_shift;
    logic [EW-1:0]     a_e, b_e;
    logic [PW-1:0]     prod;
    logic [R_LEN-1:0]  res_mask;

    assign i_last = (i_q == IW'(A_ROW - 1));
    assign j_last = (j_q == JW'(B_COL - 1));
    assign k_last = (k_q == KW'(A_COL - 1));

    // Bit offsets of A(i,k), B(k,j) and R(i,j) from the LSB; first element sits in the MSBs.
    always_comb begin : operand_select
        a_shift  = A_LEN - EW - (32'(i_q) * A_COL + 32'(k_q)) * EW;
        b_shift  = B_LEN - EW - (32'(k_q) * B_COL + 32'(j_q)) * EW;
        r_shift  = R_LEN - RW - (32'(i_q) * B_COL + 32'(j_q)) * RW;
        a_e      = EW'(a_q >> a_shift);
        b_e      = EW'(b_q >> b_shift);
        prod     = PW'(a_e) * PW'(b_e);
        res_mask = R_LEN'({RW{1'b1}});
    end

    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MAC;
            MAC:     if (k_last) state_d = WRITE;
            WRITE:   state_d = (i_last && j_last) ? DONE : MAC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : output_next
        a_d   = a_q;
        b_d   = b_q;
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        acc_d = acc_q;
        res_d = res;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a_in;
                    b_d   = b_in;
                    i_d   = '0;
                    j_d   = '0;
                    k_d   = '0;
                    acc_d = '0;
                    res_d = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + ACCW'(prod);
                k_d   = k_last ? '0 : k_q + KW'(1);
            end
            WRITE: begin
                // Truncate the accumulator into element (i,j), then step j, carrying into i.
                res_d = (res & ~(res_mask << r_shift)) | (R_LEN'(acc_q[RW-1:0]) << r_shift);
                acc_d = '0;
                if (j_last) begin
                    j_d = '0;
                    i_d = i_last ? '0 : i_q + IW'(1);
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == MAC) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin : datapath_reg
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            acc_q <= acc_d;
            res   <= res_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule

// File: tb/tb_mat_mul_sequencer.sv
// Directed and random jobs for mat_mul_sequencer, checked cycle by cycle
// against an arithmetic matrix-product model and the job timing rules.
module tb_mat_mul_sequencer;

    localparam int unsigned A_ROW  = 4;
    localparam int unsigned A_COL  = 4;
    localparam int unsigned B_COL  = 2;
    localparam int unsigned EW     = 8;
    localparam int unsigned RW     = 8;
    localparam int unsigned A_LEN  = A_ROW * A_COL * EW;
    localparam int unsigned B_LEN  = A_COL * B_COL * EW;
    localparam int unsigned R_LEN  = A_ROW * B_COL * RW;
    localparam int unsigned N_EL   = A_ROW * B_COL;
    localparam int unsigned LAST_W = N_EL * (A_COL + 1);
    localparam int unsigned PERIOD = LAST_W + 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [A_LEN-1:0] a_in;
    logic [B_LEN-1:0] b_in;
    logic             busy;
    logic             done;
    logic [R_LEN-1:0] res;

    int checks = 0;
    int errors = 0;

    mat_mul_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [R_LEN-1:0] obs, input logic [R_LEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Plain matrix product, each element reduced modulo 2^RW.
    function automatic logic [R_LEN-1:0] model(input logic [A_LEN-1:0] a, input logic [B_LEN-1:0] b);
        logic [R_LEN-1:0] r;
        int unsigned sum;
        r = '0;
        for (int i = 0; i < A_ROW; i++) begin
            for (int j = 0; j < B_COL; j++) begin
                sum = 0;
                for (int k = 0; k < A_COL; k++)
                    sum += 32'(a[A_LEN-1-(i*A_COL+k)*EW -: EW]) * 32'(b[B_LEN-1-(k*B_COL+j)*EW -: EW]);
                r[R_LEN-1-(i*B_COL+j)*RW -: RW] = RW'(sum);
            end
        end
        return r;
    endfunction

    // Result as seen n edges after acceptance: element e lands on edge (e+1)*(A_COL+1).
    function automatic logic [R_LEN-1:0] partial(input logic [R_LEN-1:0] full, input int n);
        logic [R_LEN-1:0] r;
        r = full;
        for (int e = 0; e < N_EL; e++)
            if ((e + 1) * (A_COL + 1) > n) r[R_LEN-1-e*RW -: RW] = '0;
        return r;
    endfunction

    // mode 1: a late start with zeroed A is presented mid-job and must be ignored.
    task automatic run_job(input logic [A_LEN-1:0] a, input logic [B_LEN-1:0] b, input int mode);
        logic [R_LEN-1:0] full;
        full = model(a, b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        for (int n = 0; n <= LAST_W + 1; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (mode == 1 && n == 10) begin
                start = 1'b1;
                a_in  = '0;
            end
            if (mode == 1 && n == 11) start = 1'b0;
            chk1("job_busy", busy, n <= LAST_W - 1);
            chk1("job_done", done, n == LAST_W);
            chk("job_res", res, partial(full, n));
        end
    endtask

    initial begin
        logic [A_LEN-1:0] ref_a, ones_a, id_a, ra;
        logic [B_LEN-1:0] ref_b, ones_b, rb;
        logic [R_LEN-1:0] ref_r;
        int p;

        ref_a  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd1, 8'd2, 8'd3,
                  8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd1, 8'd2, 8'd3};
        ref_b  = {8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd2, 8'd3};
        id_a   = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0,
                  8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        ones_a = '1;
        ones_b = '1;
        ref_r  = model(ref_a, ref_b);

        rst   = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #20;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk("reset_res", res, '0);
        rst = 1'b1;

        run_job(ref_a, ref_b, 0);
        chk("ref_const", res, 64'h3625_423D_3625_423D);

        run_job(ones_a, ones_b, 0);
        chk("ovf_const", res, 64'h0404_0404_0404_0404);

        run_job(id_a, ref_b, 0);
        chk("ident", res, ref_b);

        run_job(ref_a, ref_b, 1);
        chk("ignored_start", res, 64'h3625_423D_3625_423D);

        repeat (4) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom};
            run_job(ra, rb, 0);
        end

        // Abort mid-job with an asynchronous reset between clock edges.
        @(negedge clk);
        a_in  = ref_a;
        b_in  = ref_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_pre_res", res, partial(ref_r, 20));
        #2 rst = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk("mid_rst_res", res, '0);
        repeat (3) begin
            @(negedge clk);
            chk1("mid_hold_busy", busy, 1'b0);
            chk1("mid_hold_done", done, 1'b0);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("post_rst_done", done, 1'b0);
            chk("post_rst_res", res, '0);
        end
        run_job(ref_a, ref_b, 0);

        // Start held high: re-accepted on the first IDLE cycle after each DONE.
        @(negedge clk);
        a_in  = ref_a;
        b_in  = ref_b;
        start = 1'b1;
        for (int t = 0; t < 3 * PERIOD; t++) begin
            @(negedge clk);
            if (t == 99) start = 1'b0;
            p = t % PERIOD;
            chk1("hold_busy", busy, p <= LAST_W - 1);
            chk1("hold_done", done, p == LAST_W);
        end
        chk("hold_res", res, ref_r);
        @(negedge clk);
        chk1("hold_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
